// File: rtl/roimager_frame_sched_pkg.sv
// Shared definitions for the imager frame scheduler: state encoding,
// configuration table defaults and the active-length clamp.
package roimager_frame_sched_pkg;

  localparam int C_NUM_CFG  = 4;
  localparam int C_CFG_AW   = 2;
  localparam int C_EXP_DEF  = 10;
  localparam int C_NPAT_DEF = 100;

  typedef enum logic [5:0] {
    ST_WAIT_EXP = 6'b000001,
    ST_START    = 6'b000010,
    ST_READOUT  = 6'b000100,
    ST_DECIDE   = 6'b001000,
    ST_RELEASE  = 6'b010000,
    ST_HOLD     = 6'b100000
  } state_e;

  // A length of 0 behaves as 1; anything past the table size is capped.
  function automatic logic [C_CFG_AW:0] cfg_len_eff(input logic [2:0] len);
    logic [C_CFG_AW:0] r;
    if (len == 3'd0) r = (C_CFG_AW+1)'(1);
    else if (int'(len) > C_NUM_CFG) r = (C_CFG_AW+1)'(C_NUM_CFG);
    else r = (C_CFG_AW+1)'(len);
    return r;
  endfunction

endpackage

// File: rtl/roimager_cfg_table.sv
// Exposure configuration table: {Exp, Num_Pat} per entry, synchronous write,
// combinational read that always returns the pre-write contents.
module roimager_cfg_table
  import roimager_frame_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [C_CFG_AW-1:0] waddr,
  input  logic [31:0]         wexp,
  input  logic [31:0]         wnpat,
  input  logic [C_CFG_AW-1:0] raddr,
  output logic [31:0]         rexp,
  output logic [31:0]         rnpat
);

  logic [63:0] mem_q [C_NUM_CFG];
  logic [63:0] mem_d [C_NUM_CFG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = {wexp, wnpat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_CFG; i++) mem_q[i] <= {32'(C_EXP_DEF), 32'(C_NPAT_DEF)};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rexp  = mem_q[raddr][63:32];
  assign rnpat = mem_q[raddr][31:0];

endmodule

// File: rtl/roimager_frame_sched.sv
// Frame scheduler: acknowledges end-of-exposure, runs the ADC readout, loads the
// next table entry while the exposure FSM is parked, then releases the next frame.
module roimager_frame_sched
  import roimager_frame_sched_pkg::*;
#(
  parameter int unsigned C_RO_TIMEOUT = 65535
) (
  input  logic                CLKMPRE,
  input  logic                RESET,
  input  logic                CFG_WE,
  input  logic [C_CFG_AW-1:0] CFG_ADDR,
  input  logic [31:0]         CFG_EXP,
  input  logic [31:0]         CFG_NPAT,
  input  logic [2:0]          CFG_LEN,
  input  logic                RUN,
  input  logic [31:0]         NUM_FRAMES,
  input  logic                FSMIND1,
  input  logic                FSMIND0ACK,
  output logic                FSMIND0,
  output logic                FSMIND1ACK,
  output logic [31:0]         Exp_subc,
  output logic [31:0]         Num_Pat,
  output logic                RO_START,
  input  logic                RO_DONE,
  output logic [31:0]         FRAME_CNT,
  output logic [C_CFG_AW-1:0] CFG_IDX,
  output logic                BUSY,
  output logic                TIMEOUT_ERR,
  output state_e              dbg_state
);

  state_e              state_q, state_d;
  logic [31:0]         fc_q, fc_d;
  logic [C_CFG_AW-1:0] idx_q, idx_d;
  logic [31:0]         exp_q, exp_d;
  logic [31:0]         npat_q, npat_d;
  logic [31:0]         tcnt_q, tcnt_d;
  logic                to_err_q, to_err_d;
  logic                run_prev_q, run_prev_d;

  logic [C_CFG_AW-1:0] rd_addr;
  logic [31:0]         rd_exp, rd_npat;
  logic [C_CFG_AW:0]   len_eff, idx_inc;
  logic [C_CFG_AW-1:0] idx_adv;

  roimager_cfg_table u_table (
    .clk   (CLKMPRE),
    .rst   (RESET),
    .we    (CFG_WE),
    .waddr (CFG_ADDR),
    .wexp  (CFG_EXP),
    .wnpat (CFG_NPAT),
    .raddr (rd_addr),
    .rexp  (rd_exp),
    .rnpat (rd_npat)
  );

  // An index already past a shrunk length wraps straight to 0.
  always_comb begin
    len_eff = cfg_len_eff(CFG_LEN);
    idx_inc = {1'b0, idx_q} + (C_CFG_AW+1)'(1);
    idx_adv = (idx_inc >= len_eff) ? '0 : idx_inc[C_CFG_AW-1:0];
  end

  // Handshake: FSMIND1ACK stays high from the cycle after FSMIND1 until the
  // cycle after FSMIND0ACK; FSMIND0 is held until FSMIND0ACK is seen, so the
  // exposure FSM only ever sees stable Exp_subc/Num_Pat while parked.
  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    idx_d      = idx_q;
    exp_d      = exp_q;
    npat_d     = npat_q;
    tcnt_d     = tcnt_q;
    to_err_d   = to_err_q;
    run_prev_d = RUN;
    rd_addr    = idx_adv;
    FSMIND0    = 1'b0;
    FSMIND1ACK = 1'b0;
    RO_START   = 1'b0;
    BUSY       = 1'b1;
    case (state_q)
      ST_WAIT_EXP: begin
        if (FSMIND1) begin
          tcnt_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        FSMIND1ACK = 1'b1;
        RO_START   = 1'b1;
        tcnt_d     = tcnt_q + 32'd1;
        state_d    = ST_READOUT;
      end
      ST_READOUT: begin
        FSMIND1ACK = 1'b1;
        tcnt_d     = tcnt_q + 32'd1;
        if (RO_DONE || (tcnt_q + 32'd1 >= 32'(C_RO_TIMEOUT))) begin
          if (!RO_DONE) to_err_d = 1'b1;
          fc_d    = (fc_q == '1) ? fc_q : fc_q + 32'd1;
          idx_d   = idx_adv;
          exp_d   = rd_exp;
          npat_d  = rd_npat;
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        FSMIND1ACK = 1'b1;
        if (!RUN || (NUM_FRAMES != '0 && fc_q >= NUM_FRAMES)) state_d = ST_HOLD;
        else state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        FSMIND0    = 1'b1;
        FSMIND1ACK = 1'b1;
        if (FSMIND0ACK) state_d = ST_WAIT_EXP;
      end
      ST_HOLD: begin
        FSMIND1ACK = 1'b1;
        BUSY       = 1'b0;
        rd_addr    = '0;
        if (RUN && !run_prev_q) begin
          fc_d    = '0;
          idx_d   = '0;
          exp_d   = rd_exp;
          npat_d  = rd_npat;
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d  = ST_WAIT_EXP;
        fc_d     = '0;
        idx_d    = '0;
        exp_d    = 32'(C_EXP_DEF);
        npat_d   = 32'(C_NPAT_DEF);
        tcnt_d   = '0;
        to_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      state_q    <= ST_WAIT_EXP;
      fc_q       <= '0;
      idx_q      <= '0;
      exp_q      <= 32'(C_EXP_DEF);
      npat_q     <= 32'(C_NPAT_DEF);
      tcnt_q     <= '0;
      to_err_q   <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      idx_q      <= idx_d;
      exp_q      <= exp_d;
      npat_q     <= npat_d;
      tcnt_q     <= tcnt_d;
      to_err_q   <= to_err_d;
      run_prev_q <= run_prev_d;
    end
  end

  assign Exp_subc    = exp_q;
  assign Num_Pat     = npat_q;
  assign FRAME_CNT   = fc_q;
  assign CFG_IDX     = idx_q;
  assign TIMEOUT_ERR = to_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_roimager_frame_sched.sv
// Directed bench for roimager_frame_sched: handshake timing, table sequencing,
// frame limit / restart, readout timeout, reset and same-cycle table write.
module tb_roimager_frame_sched;
  import roimager_frame_sched_pkg::*;

  logic                CLKMPRE = 1'b0;
  logic                RESET = 1'b1;
  logic                CFG_WE = 1'b0;
  logic [C_CFG_AW-1:0] CFG_ADDR = '0;
  logic [31:0]         CFG_EXP = '0;
  logic [31:0]         CFG_NPAT = '0;
  logic [2:0]          CFG_LEN = 3'd4;
  logic                RUN = 1'b1;
  logic [31:0]         NUM_FRAMES = '0;
  logic                FSMIND1 = 1'b0;
  logic                FSMIND0ACK = 1'b0;
  logic                RO_DONE = 1'b0;
  logic                FSMIND0, FSMIND1ACK, RO_START, BUSY, TIMEOUT_ERR;
  logic [31:0]         Exp_subc, Num_Pat, FRAME_CNT;
  logic [C_CFG_AW-1:0] CFG_IDX;
  state_e              dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  roimager_frame_sched #(.C_RO_TIMEOUT(100)) dut (
    .CLKMPRE(CLKMPRE), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_EXP(CFG_EXP), .CFG_NPAT(CFG_NPAT), .CFG_LEN(CFG_LEN), .RUN(RUN),
    .NUM_FRAMES(NUM_FRAMES), .FSMIND1(FSMIND1), .FSMIND0ACK(FSMIND0ACK),
    .FSMIND0(FSMIND0), .FSMIND1ACK(FSMIND1ACK), .Exp_subc(Exp_subc),
    .Num_Pat(Num_Pat), .RO_START(RO_START), .RO_DONE(RO_DONE),
    .FRAME_CNT(FRAME_CNT), .CFG_IDX(CFG_IDX), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLKMPRE = ~CLKMPRE;

  task automatic step();
    @(posedge CLKMPRE);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic write_cfg(input int addr, input int e, input int n);
    CFG_WE = 1'b1;
    CFG_ADDR = C_CFG_AW'(addr);
    CFG_EXP = 32'(e);
    CFG_NPAT = 32'(n);
    step();
    CFG_WE = 1'b0;
  endtask

  // Exposure done, readout completes after dly READOUT cycles; ends in DECIDE.
  task automatic frame(input int dly);
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    repeat (dly) step();
    RO_DONE = 1'b1;
    step();
    RO_DONE = 1'b0;
  endtask

  // From DECIDE: move to RELEASE and acknowledge it.
  task automatic release_ack();
    step();
    FSMIND0ACK = 1'b1;
    step();
    FSMIND0ACK = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] e;
    int npat_seq [7] = '{2, 3, 1, 2, 3, 1, 2};
    int idx_seq  [7] = '{1, 2, 0, 1, 2, 0, 1};

    // T1: reset values and basic handshake
    do_reset();
    chk("rst_state", 32'(dbg_state), 32'(ST_WAIT_EXP));
    chk("rst_fsmind0", 32'(FSMIND0), 32'd0);
    chk("rst_ack", 32'(FSMIND1ACK), 32'd0);
    chk("rst_ro_start", 32'(RO_START), 32'd0);
    chk("rst_frame_cnt", FRAME_CNT, 32'd0);
    chk("rst_cfg_idx", 32'(CFG_IDX), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT_ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd1);
    chk("rst_exp", Exp_subc, 32'd10);
    chk("rst_npat", Num_Pat, 32'd100);
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    chk("t1_ack_rise", 32'(FSMIND1ACK), 32'd1);
    chk("t1_ro_start", 32'(RO_START), 32'd1);
    step();
    chk("t1_ro_start_single", 32'(RO_START), 32'd0);
    chk("t1_readout", 32'(dbg_state), 32'(ST_READOUT));
    repeat (18) step();
    RO_DONE = 1'b1;
    step();
    RO_DONE = 1'b0;
    chk("t1_decide", 32'(dbg_state), 32'(ST_DECIDE));
    chk("t1_frame_cnt", FRAME_CNT, 32'd1);
    chk("t1_cfg_idx", 32'(CFG_IDX), 32'd1);
    step();
    chk("t1_fsmind0", 32'(FSMIND0), 32'd1);
    repeat (3) step();
    chk("t1_fsmind0_held", 32'(FSMIND0), 32'd1);
    chk("t1_ack_held", 32'(FSMIND1ACK), 32'd1);
    FSMIND0ACK = 1'b1;
    step();
    FSMIND0ACK = 1'b0;
    chk("t1_fsmind0_drop", 32'(FSMIND0), 32'd0);
    chk("t1_ack_drop", 32'(FSMIND1ACK), 32'd0);
    chk("t1_back_wait", 32'(dbg_state), 32'(ST_WAIT_EXP));

    // T2: programmed table, 3 active entries, 7 frames
    do_reset();
    for (int i = 0; i < 4; i++) write_cfg(i, 5 * (i + 1), i + 1);
    CFG_LEN = 3'd3;
    exp_q.push_back(32'd10); exp_q.push_back(32'd15); exp_q.push_back(32'd5);
    exp_q.push_back(32'd10); exp_q.push_back(32'd15); exp_q.push_back(32'd5);
    exp_q.push_back(32'd10);
    for (int k = 0; k < 7; k++) begin
      frame(3);
      e = exp_q.pop_front();
      chk("t2_exp", Exp_subc, e);
      chk("t2_npat", Num_Pat, 32'(npat_seq[k]));
      chk("t2_idx", 32'(CFG_IDX), 32'(idx_seq[k]));
      chk("t2_frame_cnt", FRAME_CNT, 32'(k + 1));
      release_ack();
    end

    // T5: reset during READOUT and during RELEASE
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    step();
    step();
    RESET = 1'b1;
    step();
    chk("t5a_state", 32'(dbg_state), 32'(ST_WAIT_EXP));
    chk("t5a_fsmind0", 32'(FSMIND0), 32'd0);
    chk("t5a_ack", 32'(FSMIND1ACK), 32'd0);
    chk("t5a_frame_cnt", FRAME_CNT, 32'd0);
    chk("t5a_exp", Exp_subc, 32'd10);
    chk("t5a_npat", Num_Pat, 32'd100);
    RESET = 1'b0;
    frame(3);
    chk("t5a_tbl_npat", Num_Pat, 32'd100);
    chk("t5a_tbl_exp", Exp_subc, 32'd10);
    step();
    chk("t5b_in_release", 32'(FSMIND0), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("t5b_state", 32'(dbg_state), 32'(ST_WAIT_EXP));
    chk("t5b_fsmind0", 32'(FSMIND0), 32'd0);
    chk("t5b_ack", 32'(FSMIND1ACK), 32'd0);
    chk("t5b_frame_cnt", FRAME_CNT, 32'd0);
    chk("t5b_idx", 32'(CFG_IDX), 32'd0);

    // T6: write to entry 1 in the cycle entry 1 is loaded
    do_reset();
    CFG_LEN = 3'd2;
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    repeat (3) step();
    RO_DONE = 1'b1;
    CFG_WE = 1'b1;
    CFG_ADDR = C_CFG_AW'(1);
    CFG_EXP = 32'd99;
    CFG_NPAT = 32'd9;
    step();
    RO_DONE = 1'b0;
    CFG_WE = 1'b0;
    chk("t6_idx", 32'(CFG_IDX), 32'd1);
    chk("t6_old_exp", Exp_subc, 32'd10);
    chk("t6_old_npat", Num_Pat, 32'd100);
    release_ack();
    frame(3);
    chk("t6_idx0", 32'(CFG_IDX), 32'd0);
    release_ack();
    frame(3);
    chk("t6_new_exp", Exp_subc, 32'd99);
    chk("t6_new_npat", Num_Pat, 32'd9);
    release_ack();

    // T3: frame limit, HOLD, restart on RUN rising edge
    do_reset();
    write_cfg(0, 77, 7);
    CFG_LEN = 3'd4;
    NUM_FRAMES = 32'd3;
    RUN = 1'b1;
    frame(3);
    release_ack();
    frame(3);
    release_ack();
    frame(3);
    chk("t3_frame_cnt", FRAME_CNT, 32'd3);
    chk("t3_decide_fsmind0", 32'(FSMIND0), 32'd0);
    step();
    chk("t3_hold", 32'(dbg_state), 32'(ST_HOLD));
    chk("t3_busy", 32'(BUSY), 32'd0);
    chk("t3_ack", 32'(FSMIND1ACK), 32'd1);
    chk("t3_fsmind0", 32'(FSMIND0), 32'd0);
    FSMIND1 = 1'b1;
    repeat (3) step();
    FSMIND1 = 1'b0;
    chk("t3_still_hold", 32'(dbg_state), 32'(ST_HOLD));
    chk("t3_no_release", 32'(FSMIND0), 32'd0);
    RUN = 1'b0;
    step();
    RUN = 1'b1;
    step();
    chk("t3_restart_state", 32'(dbg_state), 32'(ST_RELEASE));
    chk("t3_restart_fc", FRAME_CNT, 32'd0);
    chk("t3_restart_idx", 32'(CFG_IDX), 32'd0);
    chk("t3_restart_exp", Exp_subc, 32'd77);
    chk("t3_restart_npat", Num_Pat, 32'd7);
    chk("t3_restart_fsmind0", 32'(FSMIND0), 32'd1);
    chk("t3_restart_busy", 32'(BUSY), 32'd1);
    FSMIND0ACK = 1'b1;
    step();
    FSMIND0ACK = 1'b0;
    NUM_FRAMES = 32'd0;

    // T4: readout timeout after 100 cycles, sticky error
    do_reset();
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    chk("t4_ro_start", 32'(RO_START), 32'd1);
    step();
    n = 1;
    while (dbg_state == ST_READOUT && n < 300) begin
      step();
      n++;
    end
    chk("t4_exit_cycles", 32'(n), 32'd100);
    chk("t4_timeout_err", 32'(TIMEOUT_ERR), 32'd1);
    chk("t4_frame_cnt", FRAME_CNT, 32'd1);
    release_ack();
    frame(3);
    chk("t4_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
    chk("t4_frame_cnt2", FRAME_CNT, 32'd2);
    release_ack();
    do_reset();
    chk("t4_err_cleared", 32'(TIMEOUT_ERR), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roimager_frame_sched.md
Name: roimager_frame_sched

Overview:
Frame-level scheduler for the imager exposure FSM. It is the MOBO-side partner of the FSMIND0/FSMIND1 handshake.
- Acknowledges each end-of-exposure and launches the ADC readout.
- After readout, loads the next exposure configuration (Exp_subc, Num_Pat) from a small programmable table and releases the exposure FSM into its next frame.
- Supports free-running operation, a fixed frame count, and pause/resume.

Parameters:
C_NUM_CFG, 4, number of configuration table entries (power of two)
C_CFG_AW, 2, table address width, log2(C_NUM_CFG)
C_EXP_DEF, 10, reset value of every table Exp entry (x100 CLK_HS periods)
C_NPAT_DEF, 100, reset value of every table Num_Pat entry
C_RO_TIMEOUT, 65535, maximum CLKMPRE cycles to wait for RO_DONE

Ports:
CLKMPRE  in  1  scheduler clock, same clock as the exposure FSM
RESET  in  1  synchronous, active-high reset
CFG_WE  in  1  table write strobe
CFG_ADDR  in  C_CFG_AW  table write address
CFG_EXP  in  32  Exp value to write
CFG_NPAT  in  32  Num_Pat value to write
CFG_LEN  in  3  number of active entries, 1..C_NUM_CFG; 0 is treated as 1
RUN  in  1  1 = keep releasing frames; 0 = park after current readout
NUM_FRAMES  in  32  frames per run; 0 = unlimited
FSMIND1  in  1  exposure FSM reports frame exposed
FSMIND0ACK  in  1  exposure FSM acknowledges release
FSMIND0  out  1  release exposure FSM into next frame
FSMIND1ACK  out  1  acknowledge of FSMIND1
Exp_subc  out  32  exposure setting presented to the exposure FSM
Num_Pat  out  32  pattern count presented to the exposure FSM
RO_START  out  1  one-cycle readout start pulse to the ADC sequencer
RO_DONE  in  1  readout-complete pulse or level
FRAME_CNT  out  32  frames read out since the last run start
CFG_IDX  out  C_CFG_AW  index of the entry currently presented
BUSY  out  1  high in every state except HOLD
TIMEOUT_ERR  out  1  sticky; set on readout timeout

Behaviour:
- Reset values: state WAIT_EXP; FSMIND0=0, FSMIND1ACK=0, RO_START=0, FRAME_CNT=0, CFG_IDX=0, TIMEOUT_ERR=0, BUSY=1.
  - All table entries reset to C_EXP_DEF/C_NPAT_DEF.
  - Exp_subc/Num_Pat reset to entry 0. The exposure FSM runs its first frame from reset using these values.
- Table writes are accepted in any state and in any cycle. A load in the same cycle as a write to the same entry takes the pre-write contents.
- States:
  - WAIT_EXP: wait for FSMIND1=1. Then set FSMIND1ACK=1, pulse RO_START for one cycle, clear the timeout counter, and go to READOUT.
  - READOUT: FSMIND1ACK stays 1. The timeout counter increments each cycle. Exit on RO_DONE=1, or when the counter reaches C_RO_TIMEOUT (set TIMEOUT_ERR in that case). On exit:
    - FRAME_CNT increments (saturates at 2^32-1).
    - CFG_IDX advances modulo the effective CFG_LEN.
    - Exp_subc/Num_Pat are loaded from the new index.
    - Next state is DECIDE.
  - DECIDE: one cycle. Go to HOLD if RUN=0, or if NUM_FRAMES!=0 and FRAME_CNT>=NUM_FRAMES. Otherwise go to RELEASE.
  - RELEASE: FSMIND0=1 and FSMIND1ACK=1. On FSMIND0ACK=1, drop both in the next cycle and go to WAIT_EXP. The release is complete only when the exposure FSM's own timer allows, so there is no timeout here.
  - HOLD: BUSY=0; FSMIND1ACK stays 1, so the exposure FSM stays parked. On a RUN rising edge (RUN=1 while the previous-cycle RUN=0):
    - clear FRAME_CNT;
    - reset CFG_IDX to 0 and reload Exp_subc/Num_Pat from entry 0;
    - go to RELEASE.
    - RUN held at 1 continuously with the frame limit reached does not restart the run.
  - Any illegal state encoding: go to WAIT_EXP with all outputs at their reset values.
- Exp_subc/Num_Pat change only on the READOUT exit or HOLD restart, i.e. only while the exposure FSM is parked. They are never changed during exposure.
- FSMIND1 seen while in RELEASE or HOLD is ignored; state is unchanged.
- RESET mid-operation returns to WAIT_EXP in the next cycle. The exposure FSM must be reset together with this block.
- CFG_LEN changes take effect at the next index advance. If CFG_IDX >= the new length, it wraps to 0.

Decomposition:
- Shared package holds:
  - the state encoding constants (one-hot, 6 states);
  - the reset defaults for Exp and Num_Pat;
  - the CFG_LEN clamp rule.
- One sub-module, roimager_cfg_table: C_NUM_CFG x 64-bit register file with a synchronous write port and a combinational read port, with reset to defaults.

Test Plan:
- Reset, then drive FSMIND1=1 and RO_DONE 20 cycles after RO_START -> FSMIND1ACK=1 one cycle after FSMIND1; RO_START is a single cycle; FRAME_CNT=1, CFG_IDX=1, FSMIND0=1 until FSMIND0ACK.
- Table written with Exp={5,10,15,20}, Num_Pat={1,2,3,4}, CFG_LEN=3, 7 frames -> presented Exp sequence 10,15,5,10,15,5,10 (index wraps 0..2).
- NUM_FRAMES=3, RUN=1 -> after the 3rd readout enters HOLD with BUSY=0 and FSMIND0 never asserted; RUN toggled 0->1 -> FRAME_CNT=0, CFG_IDX=0, release issued.
- RO_DONE withheld with C_RO_TIMEOUT=100 -> exit READOUT exactly 100 cycles after RO_START; TIMEOUT_ERR=1 and stays set through later normal frames until RESET.
- RESET asserted during READOUT and during RELEASE -> next cycle state WAIT_EXP, FSMIND0=0, FSMIND1ACK=0, FRAME_CNT=0, table back to 10/100.
- CFG_WE to entry 1 in the same cycle as the load of entry 1 -> old value presented; new value presented on the next visit to entry 1.
